instr_mem_responder: RTL



---
 rtl/instr_mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: serves req/gnt/rvalid fetches from a word SRAM
// with a fixed read latency, bounded outstanding count and a program-load port.
module instr_mem_responder #(
    parameter int          MEM_DEPTH       = 1024,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int               IDX_W   = $clog2(MEM_DEPTH);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0]      SPAN    = 33'(MEM_DEPTH) << 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [31:0] mem_q [MEM_DEPTH];

    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [LATENCY-1:0]       err_q, err_d;
    logic [LATENCY-1:0][31:0] data_q, data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [31:0]      fetch_off;
    logic             fetch_misaligned;
    logic             fetch_oor;
    logic             fetch_ok;
    logic [IDX_W-1:0] fetch_idx;
    logic [31:0]      load_off;
    logic             load_in_range;
    logic [IDX_W-1:0] load_idx;
    logic             rsp_fire;
    logic             gnt;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land out of range.
    always_comb begin
        fetch_off        = instr_addr_i - BASE_ADDR;
        fetch_misaligned = (instr_addr_i[1:0] != 2'b00);
        fetch_oor        = ({1'b0, fetch_off} >= SPAN);
        fetch_ok         = ~fetch_misaligned & ~fetch_oor;
        fetch_idx        = fetch_off[IDX_W+1:2];
        load_off         = load_addr_i - BASE_ADDR;
        load_in_range    = ({1'b0, load_off} < SPAN);
        load_idx         = load_off[IDX_W+1:2];
    end

    // A response leaving the pipeline frees a slot in the same cycle.
    always_comb begin
        rsp_fire = vld_q[LATENCY-1];
        gnt      = instr_req_i & ~load_we_i & ~rst_i
                   & ((cnt_q < CNT_MAX) | rsp_fire);
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({gnt, rsp_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Empty slots carry zero data and error so the outputs idle at zero.
    always_comb begin
        vld_d     = '0;
        err_d     = '0;
        data_d    = '0;
        vld_d[0]  = gnt;
        err_d[0]  = gnt & ~fetch_ok;
        data_d[0] = (gnt & fetch_ok) ? mem_q[fetch_idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // The image survives reset so a boot loader can load before releasing the core.
    always_ff @(posedge clk_i) begin
        if (load_we_i && load_in_range) begin
            mem_q[load_idx] <= load_wdata_i;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_rdata_o  = data_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];

endmodule
